// File: rtl/repeat_nfa_strmatch_if.sv
// repeat_nfa_strmatch_if: byte stream, configuration and match result bundle for the NFA matcher
interface repeat_nfa_strmatch_if #(parameter int DEPTH = 8, parameter int CNT_W = 16);
  localparam int IW = $clog2(DEPTH);
  logic en;
  logic valid;
  logic [7:0] payload;
  logic cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [7:0] cfg_char;
  logic [1:0] cfg_mode;
  logic cfg_len_we;
  logic [IW:0] cfg_len;
  logic match;
  logic [CNT_W-1:0] match_count;
  modport master (
    output en, valid, payload, cfg_we, cfg_idx, cfg_char, cfg_mode, cfg_len_we, cfg_len,
    input match, match_count
  );
  modport slave (
    input en, valid, payload, cfg_we, cfg_idx, cfg_char, cfg_mode, cfg_len_we, cfg_len,
    output match, match_count
  );
endinterface

// File: rtl/repeat_nfa_strmatch.sv
// repeat_nfa_strmatch: shift-and NFA string matcher with literal, any, one-or-more and not-literal stages
module repeat_nfa_strmatch #(parameter int DEPTH = 8, parameter int CNT_W = 16) (
  input logic clk,
  input logic reset_n,
  repeat_nfa_strmatch_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  logic [7:0] chr [DEPTH];
  logic [1:0] mode [DEPTH];
  logic [DEPTH-1:0] s, s_next, prev, step, sel;
  logic [LW-1:0] len, len_next;
  logic [CNT_W-1:0] cnt;
  logic match_q, match_next, clr;
  always_comb begin
    clr = bus.cfg_we | bus.cfg_len_we;
    prev = {s[DEPTH-2:0], bus.en};
    len_next = bus.cfg_len_we ? ((bus.cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.cfg_len) : len;
    step = '0;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      step[i] = (prev[i] | (mode[i] == 2'd2 & s[i])) &
                (mode[i] == 2'd1 | ((bus.payload == chr[i]) ^ (mode[i] == 2'd3)));
      sel[i] = len_next == LW'(i + 1);
    end
    s_next = clr ? '0 : bus.valid ? step : s;
    match_next = |(s_next & sel);
  end
  // match is registered from the same next-state that loads s, so it tracks s[LEN-1] exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s <= '0;
      len <= '0;
      match_q <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        chr[i] <= 8'h00;
        mode[i] <= 2'd0;
      end
    end else begin
      s <= s_next;
      len <= len_next;
      match_q <= match_next;
      if (!match_q && match_next && cnt != '1) cnt <= cnt + 1'b1;
      if (bus.cfg_we && {1'b0, bus.cfg_idx} < LW'(DEPTH)) begin
        chr[bus.cfg_idx] <= bus.cfg_char;
        mode[bus.cfg_idx] <= bus.cfg_mode;
      end
    end
  end
  assign bus.match = match_q;
  assign bus.match_count = cnt;
endmodule

// File: tb/tb_repeat_nfa_strmatch.sv
// tb_repeat_nfa_strmatch: scenario tasks with a queue scoreboard of expected match per driven cycle
module tb_repeat_nfa_strmatch;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  logic obs_q[$];
  always #5 clk = ~clk;
  repeat_nfa_strmatch_if #(.DEPTH(8), .CNT_W(2)) bus ();
  repeat_nfa_strmatch #(.DEPTH(8), .CNT_W(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  task automatic step(input logic [7:0] p, input logic v, input logic e);
    bus.payload = p;
    bus.valid = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back(bus.match);
    bus.cfg_we = 1'b0;
    bus.cfg_len_we = 1'b0;
    bus.valid = 1'b0;
  endtask

  task automatic set_stage(input int idx, input logic [7:0] c, input logic [1:0] m);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = 3'(idx);
    bus.cfg_char = c;
    bus.cfg_mode = m;
    step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic set_len(input logic [3:0] l);
    bus.cfg_len_we = 1'b1;
    bus.cfg_len = l;
    step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic program_abc();
    set_stage(0, "a", 2'd0);
    set_stage(1, "b", 2'd0);
    set_stage(2, "c", 2'd0);
    set_len(4'd3);
  endtask

  task automatic apply_reset();
    bus.en = 1'b0;
    bus.valid = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_len_we = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks += 2;
    if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_match got=%b exp=0", bus.match); end
    if (bus.match_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.match_count); end
    apply_reset();
  endtask

  task automatic test_literal();
    logic e, o;
    apply_reset();
    program_abc();
    bus.en = 1'b1;
    step("a", 1, 0); step("b", 1, 0); step("c", 1, 1); step("x", 1, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL literal[%0d] match got=%b exp=%b", k, o, e); end
    end
    checks++;
    if (bus.match_count !== 2'd1) begin errors++; $display("FAIL literal_count got=%0d exp=1", bus.match_count); end
  endtask

  task automatic test_plus();
    logic e, o;
    apply_reset();
    set_stage(0, "a", 2'd0);
    set_stage(1, "b", 2'd2);
    set_stage(2, "c", 2'd0);
    set_len(4'd3);
    bus.en = 1'b1;
    step("a", 1, 0); step("b", 1, 0); step("b", 1, 0); step("b", 1, 0); step("c", 1, 1);
    step("a", 1, 0); step("c", 1, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL plus[%0d] match got=%b exp=%b", k, o, e); end
    end
    checks++;
    if (bus.match_count !== 2'd1) begin errors++; $display("FAIL plus_count got=%0d exp=1", bus.match_count); end
  endtask

  task automatic test_any_not();
    logic e, o;
    apply_reset();
    set_stage(0, "a", 2'd0);
    set_stage(1, "q", 2'd1);
    set_stage(2, "c", 2'd0);
    set_len(4'd3);
    bus.en = 1'b1;
    step("a", 1, 0); step("z", 1, 0); step("c", 1, 1);
    set_stage(1, "x", 2'd3);
    step("a", 1, 0); step("z", 1, 0); step("c", 1, 1);
    step("a", 1, 0); step("x", 1, 0); step("c", 1, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL any_not[%0d] match got=%b exp=%b", k, o, e); end
    end
    checks++;
    if (bus.match_count !== 2'd2) begin errors++; $display("FAIL any_not_count got=%0d exp=2", bus.match_count); end
  endtask

  task automatic test_gaps();
    logic e, o;
    apply_reset();
    program_abc();
    bus.en = 1'b1;
    step("a", 1, 0); step("b", 0, 0); step("b", 0, 0); step("b", 1, 0); step("c", 1, 1);
    step("x", 0, 1); step("x", 1, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL gaps[%0d] match got=%b exp=%b", k, o, e); end
    end
  endtask

  task automatic test_cfg_clear();
    logic e, o;
    apply_reset();
    program_abc();
    bus.en = 1'b1;
    step("a", 1, 0); step("b", 1, 0);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_char = "a"; bus.cfg_mode = 2'd0;
    step("c", 1, 0);
    step("c", 1, 0);
    step("a", 1, 0); step("b", 1, 0);
    bus.cfg_len_we = 1'b1; bus.cfg_len = 4'd3;
    step("c", 1, 0);
    step("a", 1, 0); step("b", 1, 0); step("c", 1, 1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL cfg_clear[%0d] match got=%b exp=%b", k, o, e); end
    end
    checks++;
    if (bus.match_count !== 2'd1) begin errors++; $display("FAIL cfg_clear_count got=%0d exp=1", bus.match_count); end
  endtask

  task automatic test_len();
    logic e, o;
    apply_reset();
    for (int i = 0; i < 8; i++) set_stage(i, 8'h00, 2'd1);
    set_len(4'd15);
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) step(8'(i), 1, 0);
    step("h", 1, 1); step("i", 1, 1);
    set_len(4'd0);
    step("a", 1, 0); step("b", 1, 0); step("c", 1, 0);
    set_len(4'd2);
    step("x", 1, 0); step("y", 1, 1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL len[%0d] match got=%b exp=%b", k, o, e); end
    end
    checks++;
    if (bus.match_count !== 2'd2) begin errors++; $display("FAIL len_count got=%0d exp=2", bus.match_count); end
  endtask

  task automatic test_back_to_back();
    logic e, o;
    apply_reset();
    set_stage(0, "a", 2'd0);
    set_stage(1, "a", 2'd0);
    set_len(4'd2);
    bus.en = 1'b1;
    step("a", 1, 0); step("a", 1, 1); step("a", 1, 1); step("b", 1, 0); step("a", 1, 0); step("a", 1, 1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back[%0d] match got=%b exp=%b", k, o, e); end
    end
    checks++;
    if (bus.match_count !== 2'd2) begin errors++; $display("FAIL back_to_back_count got=%0d exp=2", bus.match_count); end
  endtask

  task automatic test_saturate();
    logic e, o;
    apply_reset();
    program_abc();
    bus.en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      step("a", 1, 0); step("b", 1, 0); step("c", 1, 1); step("x", 1, 0);
      checks++;
      if (bus.match_count !== 2'((r + 1 > 3) ? 3 : r + 1)) begin
        errors++; $display("FAIL saturate_count[%0d] got=%0d exp=%0d", r, bus.match_count, (r + 1 > 3) ? 3 : r + 1);
      end
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL saturate[%0d] match got=%b exp=%b", k, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic e, o;
    apply_reset();
    program_abc();
    bus.en = 1'b1;
    step("a", 1, 0); step("b", 1, 0); step("c", 1, 1);
    step("a", 1, 0); step("b", 1, 0);
    #3 reset_n = 1'b0;
    #1;
    checks += 2;
    if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_mid_match got=%b exp=0", bus.match); end
    if (bus.match_count !== 2'd0) begin errors++; $display("FAIL reset_mid_count got=%0d exp=0", bus.match_count); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("c", 1, 0); step("c", 1, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_mid[%0d] match got=%b exp=%b", k, o, e); end
    end
    checks++;
    if (bus.match_count !== 2'd0) begin errors++; $display("FAIL reset_mid_final_count got=%0d exp=0", bus.match_count); end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.valid = 1'b0;
    bus.payload = 8'h00;
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_char = 8'h00;
    bus.cfg_mode = 2'd0;
    bus.cfg_len_we = 1'b0;
    bus.cfg_len = '0;
    test_reset();
    test_literal();
    test_plus();
    test_any_not();
    test_gaps();
    test_cfg_clear();
    test_len();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/repeat_nfa_strmatch.md
REPEAT_NFA_STRMATCH -- requirements
Module: repeat_nfa_strmatch

Interface
REQ-001 Parameter DEPTH, default 8: number of NFA character stages, legal range 2..32.
REQ-002 Parameter CNT_W, default 16: width of the match event counter, legal range 2..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  start enable; stage 0 may activate on the current byte when high.
REQ-006 valid  input  1  payload qualifier; when low, the byte is ignored and all stage state holds.
REQ-007 payload  input  8  input byte stream, one byte per valid cycle.
REQ-008 cfg_we  input  1  configuration write strobe.
REQ-009 cfg_idx  input  clog2(DEPTH)  stage index written by cfg_we.
REQ-010 cfg_char  input  8  pattern byte for stage cfg_idx.
REQ-011 cfg_mode  input  2  stage mode: 0 literal, 1 any byte, 2 literal one-or-more (+), 3 not-literal.
REQ-012 cfg_len_we  input  1  pattern length write strobe.
REQ-013 cfg_len  input  clog2(DEPTH)+1  active pattern length in stages.
REQ-014 match  output  1  high when the last active stage is active.
REQ-015 match_count  output  CNT_W  saturating count of match rising events.

Function
REQ-016 Stage i SHALL hold char_i, mode_i and state bit s_i.
REQ-017 hit_i SHALL be: mode 0/2 payload==char_i; mode 1 always 1; mode 3 payload!=char_i.
REQ-018 prev_0 SHALL be en; prev_i SHALL be s_(i-1) for i>=1.
REQ-019 On a valid cycle, modes 0/1/3 SHALL load s_i <= prev_i & hit_i.
REQ-020 On a valid cycle, mode 2 SHALL load s_i <= (prev_i | s_i) & hit_i (self-loop repetition).
REQ-021 On a non-valid cycle, every s_i SHALL hold.
REQ-022 match SHALL equal s_(LEN-1), driven directly from flops; latency one clock after the final byte is sampled.
REQ-023 LEN SHALL be the stored length; LEN=0 forces match=0; a written cfg_len>DEPTH SHALL be stored as DEPTH.
REQ-024 cfg_we SHALL update char/mode of stage cfg_idx at the clock edge; a cfg_idx>=DEPTH write SHALL be ignored.
REQ-025 cfg_we or cfg_len_we SHALL clear all s_i at the same edge, overriding the matching update for that cycle.
REQ-026 match_count SHALL increment by 1 on each cycle where match is 0 and the next value of match is 1.
REQ-027 match_count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-028 Overlapping matches SHALL be detected: en held high restarts stage 0 on every valid byte.
REQ-029 Stages at index >=LEN SHALL continue to update but SHALL NOT affect match.

Reset
REQ-030 reset_n low SHALL immediately clear all s_i, match, match_count and LEN to 0.
REQ-031 reset_n low SHALL clear all char_i to 8'h00 and mode_i to 0.
REQ-032 Reset asserted mid-match SHALL discard partial progress; no match SHALL be reported from pre-reset bytes.

Verification
REQ-033 Program "abc" literal, LEN=3, en=1, valid=1, feed a,b,c -> match=1 one cycle after 'c', match_count=1.
REQ-034 Program a,b(mode 2),c, LEN=3, feed a,b,b,b,c -> single match pulse after 'c'; feed a,c -> no match.
REQ-035 Program a,any,c and a,!x,c, feed "azc" then "axc" -> match for "azc" in both; no match for "axc" under !x.
REQ-036 Feed a,b with valid toggling 1,0,0,1 before 'c' -> match still asserts after 'c'; s_i held during gaps.
REQ-037 Assert cfg_we after "ab" of "abc", then feed 'c' -> no match; CNT_W=2, six separate matches -> match_count=3.
REQ-038 Pull reset_n low asynchronously after "ab", release, feed 'c' -> match stays 0, all outputs 0 during reset.
